// File: rtl/quar_lock_ctrl_pkg.sv
// Shared types and constants for the passcode/quarantine panel sequencer.
// Character geometry, FSM state enumeration and one-hot cursor positions.
package quar_pkg;

    localparam int CHAR_W = 4;
    localparam int NCHARS = 4;
    localparam int CODE_W = CHAR_W * NCHARS;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_GRANTED = 3'd3,
        ST_LOCKOUT = 3'd4
    } quar_state_e;

    localparam logic [NCHARS-1:0] PTR_AN0 = 4'b0001;
    localparam logic [NCHARS-1:0] PTR_AN1 = 4'b0010;
    localparam logic [NCHARS-1:0] PTR_AN2 = 4'b0100;
    localparam logic [NCHARS-1:0] PTR_AN3 = 4'b1000;

endpackage

// File: rtl/quar_lock_ctrl_if.sv
// Panel bus: debounced button/level inputs and char values in, cursor/status out.
// The sequencer is the slave; whoever drives buttons and reads status is the master.
interface quar_lock_if;
    import quar_pkg::*;

    logic              LOA;
    logic              PULC;
    logic              PULL;
    logic              PULR;
    logic [CODE_W-1:0] char_in;
    logic [NCHARS-1:0] ptr;
    logic              entry_en;
    logic              clr_chars;
    logic              granted;
    logic              locked;
    logic [1:0]        tries_left;
    logic [15:0]       led;

    modport master (
        output LOA, PULC, PULL, PULR, char_in,
        input  ptr, entry_en, clr_chars, granted, locked, tries_left, led
    );

    modport slave (
        input  LOA, PULC, PULL, PULR, char_in,
        output ptr, entry_en, clr_chars, granted, locked, tries_left, led
    );

endinterface

// File: rtl/quar_lock_ctrl_tick_gen.sv
// Lockout tick divider: counts enabled cycles and fires a 1-cycle tick on wrap.
// Held at zero whenever clr is high so every lockout starts a fresh period.
module quar_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick  = en && !clr && (cnt_q == LAST);
    assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge CLOCK) begin
        if (RESET || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quar_lock_ctrl.sv
// Passcode panel sequencer: cursor, entry gating, code check, retry count and
// timed lockout with LED countdown bar. All outputs come straight from flops.
module quar_lock_ctrl
    import quar_pkg::*;
#(
    parameter logic [CODE_W-1:0] CODE       = 16'h1234,
    parameter int                MAX_TRIES  = 3,
    parameter int                LOCK_TICKS = 16,
    parameter int                TICK_DIV   = 50000000
) (
    input  logic      CLOCK,
    input  logic      RESET,
    quar_lock_if.slave bus
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_ENTRY   = ST_ENTRY;
    localparam logic [2:0] S_CHECK   = ST_CHECK;
    localparam logic [2:0] S_GRANTED = ST_GRANTED;
    localparam logic [2:0] S_LOCKOUT = ST_LOCKOUT;

    localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);
    localparam logic [4:0] REM_INIT   = 5'(LOCK_TICKS);

    logic [2:0]        state_q, state_d;
    logic [NCHARS-1:0] ptr_q, ptr_d;
    logic [1:0]        tries_q, tries_d;
    logic [4:0]        rem_q, rem_d;
    logic [15:0]       led_q, led_d;
    logic              entry_en_q, entry_en_d;
    logic              clr_q, clr_d;
    logic              granted_q, granted_d;
    logic              locked_q, locked_d;
    logic              tick;

    // Thermometer bar: one lit LED per remaining lockout tick.
    function automatic logic [15:0] bar(input logic [4:0] n);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = (5'(i) < n);
        end
        return r;
    endfunction

    quar_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .clr  (state_q != S_LOCKOUT),
        .en   (state_q == S_LOCKOUT),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tries_d    = tries_q;
        rem_d      = rem_q;
        led_d      = led_q;
        entry_en_d = 1'b0;
        clr_d      = 1'b0;
        granted_d  = 1'b0;
        locked_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ptr_d = PTR_AN0;
                if (bus.LOA) begin
                    state_d    = S_ENTRY;
                    entry_en_d = 1'b1;
                    clr_d      = 1'b1;
                end
            end
            S_ENTRY: begin
                if (!bus.LOA) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    ptr_d   = PTR_AN0;
                end else if (bus.PULC) begin
                    state_d = S_CHECK;
                end else begin
                    entry_en_d = 1'b1;
                    // Simultaneous left+right cancels; edges saturate.
                    if (bus.PULL && !bus.PULR && ptr_q != PTR_AN3) begin
                        ptr_d = ptr_q << 1;
                    end else if (bus.PULR && !bus.PULL && ptr_q != PTR_AN0) begin
                        ptr_d = ptr_q >> 1;
                    end
                end
            end
            S_CHECK: begin
                if (bus.char_in == CODE) begin
                    state_d   = S_GRANTED;
                    granted_d = 1'b1;
                    tries_d   = TRIES_INIT;
                end else if (tries_q > 2'd1) begin
                    state_d    = S_ENTRY;
                    tries_d    = tries_q - 2'd1;
                    entry_en_d = 1'b1;
                    clr_d      = 1'b1;
                    ptr_d      = PTR_AN0;
                end else begin
                    state_d  = S_LOCKOUT;
                    tries_d  = 2'd0;
                    locked_d = 1'b1;
                    rem_d    = REM_INIT;
                    led_d    = bar(REM_INIT);
                end
            end
            S_GRANTED: begin
                if (bus.LOA) begin
                    granted_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    ptr_d   = PTR_AN0;
                end
            end
            S_LOCKOUT: begin
                locked_d = 1'b1;
                if (tick) begin
                    rem_d = rem_q - 5'd1;
                    led_d = bar(rem_d);
                    if (rem_d == 5'd0) begin
                        locked_d   = 1'b0;
                        tries_d    = TRIES_INIT;
                        clr_d      = 1'b1;
                        ptr_d      = PTR_AN0;
                        state_d    = bus.LOA ? S_ENTRY : S_IDLE;
                        entry_en_d = bus.LOA;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = PTR_AN0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_AN0;
            tries_q    <= TRIES_INIT;
            rem_q      <= 5'd0;
            led_q      <= 16'h0000;
            entry_en_q <= 1'b0;
            clr_q      <= 1'b0;
            granted_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tries_q    <= tries_d;
            rem_q      <= rem_d;
            led_q      <= led_d;
            entry_en_q <= entry_en_d;
            clr_q      <= clr_d;
            granted_q  <= granted_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.ptr        = ptr_q;
    assign bus.entry_en   = entry_en_q;
    assign bus.clr_chars  = clr_q;
    assign bus.granted    = granted_q;
    assign bus.locked     = locked_q;
    assign bus.tries_left = tries_q;
    assign bus.led        = led_q;

endmodule

// File: tb/tb_quar_lock_ctrl.sv
// Directed bench for quar_lock_ctrl: expected output snapshots are queued per
// driven cycle and checked against the DUT one clock later.
module tb_quar_lock_ctrl;

    logic CLOCK = 1'b0;
    logic RESET;

    quar_lock_if bus_if ();

    quar_lock_ctrl #(
        .CODE      (16'h1234),
        .MAX_TRIES (3),
        .LOCK_TICKS(4),
        .TICK_DIV  (4)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus_if)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        string       tag;
        logic [25:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // {ptr, entry_en, clr_chars, granted, locked, tries_left, led}
    function automatic logic [25:0] pk(input logic [3:0] p, input logic en, input logic cl,
                                       input logic gr, input logic lk, input logic [1:0] t,
                                       input logic [15:0] l);
        return {p, en, cl, gr, lk, t, l};
    endfunction

    function automatic logic [25:0] obs();
        return {bus_if.ptr, bus_if.entry_en, bus_if.clr_chars, bus_if.granted,
                bus_if.locked, bus_if.tries_left, bus_if.led};
    endfunction

    // Queue the expectation, let one rising edge pass, check on the falling edge.
    task automatic cyc(input string tag, input logic [25:0] exp);
        sb_t         e;
        logic [25:0] o;
        sb_q.push_back('{tag: tag, exp: exp});
        @(negedge CLOCK);
        e = sb_q.pop_front();
        o = obs();
        n_cmp++;
        assert (o === e.exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed ptr=%b en=%b clr=%b gr=%b lk=%b tries=%0d led=%h, expected ptr=%b en=%b clr=%b gr=%b lk=%b tries=%0d led=%h",
                   e.tag, o[25:22], o[21], o[20], o[19], o[18], o[17:16], o[15:0],
                   e.exp[25:22], e.exp[21], e.exp[20], e.exp[19], e.exp[18], e.exp[17:16], e.exp[15:0]);
        end
    endtask

    // Three wrong submissions from ENTRY at ptr=0001, ending in the first LOCKOUT cycle.
    task automatic bad_attempts(input string pfx);
        bus_if.char_in = 16'h0000;
        for (int t = 3; t >= 1; t--) begin
            bus_if.PULC = 1'b1;
            cyc($sformatf("%s_chk%0d", pfx, t), pk(4'b0001, 0, 0, 0, 0, 2'(t), 16'h0));
            bus_if.PULC = 1'b0;
            if (t > 1)
                cyc($sformatf("%s_retry%0d", pfx, t), pk(4'b0001, 1, 1, 0, 0, 2'(t - 1), 16'h0));
            else
                cyc($sformatf("%s_lock", pfx), pk(4'b0001, 0, 0, 0, 1, 2'd0, 16'h000F));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET          = 1'b1;
        bus_if.LOA     = 1'b0;
        bus_if.PULC    = 1'b0;
        bus_if.PULL    = 1'b0;
        bus_if.PULR    = 1'b0;
        bus_if.char_in = 16'h0000;
        @(negedge CLOCK);

        // 1. reset
        cyc("reset1", pk(4'b0001, 0, 0, 0, 0, 2'd3, 16'h0));
        cyc("reset2", pk(4'b0001, 0, 0, 0, 0, 2'd3, 16'h0));
        RESET = 1'b0;
        cyc("idle", pk(4'b0001, 0, 0, 0, 0, 2'd3, 16'h0));

        // 2. arm and cursor movement
        bus_if.LOA = 1'b1;
        cyc("loa_rise", pk(4'b0001, 1, 1, 0, 0, 2'd3, 16'h0));
        cyc("entry_hold", pk(4'b0001, 1, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULL = 1'b1;
        cyc("pull1", pk(4'b0010, 1, 0, 0, 0, 2'd3, 16'h0));
        cyc("pull2", pk(4'b0100, 1, 0, 0, 0, 2'd3, 16'h0));
        cyc("pull3", pk(4'b1000, 1, 0, 0, 0, 2'd3, 16'h0));
        cyc("pull4_sat", pk(4'b1000, 1, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULR = 1'b1;
        cyc("pull_pulr", pk(4'b1000, 1, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULL = 1'b0;
        cyc("pulr", pk(4'b0100, 1, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULR = 1'b0;

        // 3. correct code
        bus_if.char_in = 16'h1234;
        bus_if.PULC    = 1'b1;
        cyc("ok_check", pk(4'b0100, 0, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULC = 1'b0;
        cyc("granted", pk(4'b0100, 0, 0, 1, 0, 2'd3, 16'h0));
        bus_if.PULL = 1'b1;
        cyc("granted_hold", pk(4'b0100, 0, 0, 1, 0, 2'd3, 16'h0));
        bus_if.PULL = 1'b0;
        bus_if.LOA  = 1'b0;
        cyc("granted_exit", pk(4'b0001, 0, 1, 0, 0, 2'd3, 16'h0));
        cyc("idle2", pk(4'b0001, 0, 0, 0, 0, 2'd3, 16'h0));

        // 4. three failures -> lockout countdown -> back to ENTRY
        bus_if.LOA = 1'b1;
        cyc("rearm", pk(4'b0001, 1, 1, 0, 0, 2'd3, 16'h0));
        bus_if.PULL = 1'b1;
        cyc("move_before_bad", pk(4'b0010, 1, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULL    = 1'b0;
        bus_if.char_in = 16'h0000;
        bus_if.PULC    = 1'b1;
        cyc("bad_chk_ptr", pk(4'b0010, 0, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULC = 1'b0;
        cyc("bad_retry_ptr", pk(4'b0001, 1, 1, 0, 0, 2'd2, 16'h0));
        bus_if.PULC = 1'b1;
        cyc("bad_chk2", pk(4'b0001, 0, 0, 0, 0, 2'd2, 16'h0));
        bus_if.PULC = 1'b0;
        cyc("bad_retry2", pk(4'b0001, 1, 1, 0, 0, 2'd1, 16'h0));
        bus_if.PULC = 1'b1;
        cyc("bad_chk3", pk(4'b0001, 0, 0, 0, 0, 2'd1, 16'h0));
        bus_if.PULC = 1'b0;
        cyc("lock_enter", pk(4'b0001, 0, 0, 0, 1, 2'd0, 16'h000F));
        for (int k = 1; k <= 15; k++) begin
            bus_if.PULC = (k == 5);
            bus_if.LOA  = (k != 9);
            cyc($sformatf("lock_k%0d", k),
                pk(4'b0001, 0, 0, 0, 1, 2'd0, 16'((1 << (4 - k / 4)) - 1)));
        end
        bus_if.PULC = 1'b0;
        bus_if.LOA  = 1'b1;
        cyc("lock_exit", pk(4'b0001, 1, 1, 0, 0, 2'd3, 16'h0));
        cyc("post_lock", pk(4'b0001, 1, 0, 0, 0, 2'd3, 16'h0));

        // 5. reset in the middle of a lockout
        bad_attempts("rl");
        for (int k = 1; k <= 8; k++) begin
            cyc($sformatf("rl_k%0d", k),
                pk(4'b0001, 0, 0, 0, 1, 2'd0, 16'((1 << (4 - k / 4)) - 1)));
        end
        RESET      = 1'b1;
        bus_if.LOA = 1'b0;
        cyc("rst_mid_lock", pk(4'b0001, 0, 0, 0, 0, 2'd3, 16'h0));
        RESET = 1'b0;
        cyc("post_rst_idle", pk(4'b0001, 0, 0, 0, 0, 2'd3, 16'h0));

        // 6. PULC wins over PULL; right edge saturates
        bus_if.LOA = 1'b1;
        cyc("rearm2", pk(4'b0001, 1, 1, 0, 0, 2'd3, 16'h0));
        bus_if.PULR = 1'b1;
        cyc("pulr_sat", pk(4'b0001, 1, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULR = 1'b0;
        bus_if.PULL = 1'b1;
        cyc("pull_to_an1", pk(4'b0010, 1, 0, 0, 0, 2'd3, 16'h0));
        bus_if.char_in = 16'h1234;
        bus_if.PULC    = 1'b1;
        cyc("pulc_pull", pk(4'b0010, 0, 0, 0, 0, 2'd3, 16'h0));
        bus_if.PULC = 1'b0;
        bus_if.PULL = 1'b0;
        cyc("pulc_pull_grant", pk(4'b0010, 0, 0, 1, 0, 2'd3, 16'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
